// File: rtl/malu_iter_if.sv
// Issue-side request/response handshake for the iterative M-extension unit.
// Names follow the unit's view: i_* are driven by the issue stage, o_* by the unit.
interface malu_iter_if #(
    parameter int XLEN = 32
);
    logic            i_valid;
    logic            o_ready;
    logic [2:0]      i_op;
    logic [XLEN-1:0] i_x;
    logic [XLEN-1:0] i_y;
    logic            i_flush;
    logic            o_valid;
    logic            i_ready;
    logic [XLEN-1:0] o_res;

    modport slave (
        input  i_valid, i_op, i_x, i_y, i_flush, i_ready,
        output o_ready, o_valid, o_res
    );

    modport master (
        output i_valid, i_op, i_x, i_y, i_flush, i_ready,
        input  o_ready, o_valid, o_res
    );
endinterface

// File: rtl/malu_iter.sv
// Iterative RV32M execute unit: radix-2 shift-add multiply, restoring divide.
// One setup cycle converts operands to magnitudes, then XLEN iterations run.
module malu_iter #(
    parameter int XLEN = 32
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    malu_iter_if.slave  bus
);
    localparam int CW = $clog2(XLEN + 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      op_q, op_d;
    logic            setup_q, setup_d;
    logic            neg_q, neg_d;
    logic            rneg_q, rneg_d;
    logic            spec_q, spec_d;
    logic [XLEN-1:0] spec_res_q, spec_res_d;
    logic [XLEN-1:0] hi_q, hi_d;
    logic [XLEN-1:0] lo_q, lo_d;
    logic [XLEN-1:0] b_q, b_d;
    logic [XLEN-1:0] res_q, res_d;

    function automatic logic sgn_x(input logic [2:0] op);
        return op[2] ? ~op[0] : (op[1:0] != 2'b11);
    endfunction

    function automatic logic sgn_y(input logic [2:0] op);
        return op[2] ? ~op[0] : ~op[1];
    endfunction

    logic            is_div;
    logic [XLEN:0]   add_sum;
    logic [XLEN:0]   rsh;
    logic            ge;
    logic [XLEN-1:0] rdiff;
    logic [XLEN-1:0] hi_n, lo_n;
    logic [2*XLEN-1:0] prod, prod_s;
    logic [XLEN-1:0] q_s, r_s, fin_res;
    logic            sx, sy;
    logic [XLEN-1:0] mx, my;
    logic            in_zero, in_ovf;

    assign is_div  = op_q[2];
    assign add_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
    assign rsh     = {hi_q, lo_q[XLEN-1]};
    assign ge      = rsh >= {1'b0, b_q};
    assign rdiff   = rsh[XLEN-1:0] - b_q;
    assign hi_n    = is_div ? (ge ? rdiff : rsh[XLEN-1:0])
                            : add_sum[XLEN:1];
    assign lo_n    = is_div ? {lo_q[XLEN-2:0], ge}
                            : {add_sum[0], lo_q[XLEN-1:1]};
    assign prod    = {hi_n, lo_n};
    assign prod_s  = neg_q ? -prod : prod;
    assign q_s     = neg_q ? -lo_n : lo_n;
    assign r_s     = rneg_q ? -hi_n : hi_n;

    // During setup lo_q/b_q still hold the raw x/y latched at accept.
    assign sx = sgn_x(op_q) & lo_q[XLEN-1];
    assign sy = sgn_y(op_q) & b_q[XLEN-1];
    assign mx = sx ? -lo_q : lo_q;
    assign my = sy ? -b_q : b_q;

    assign in_zero = (bus.i_y == '0);
    assign in_ovf  = ~bus.i_op[0]
                   & (bus.i_x == {1'b1, {(XLEN-1){1'b0}}})
                   & (bus.i_y == '1);

    always_comb begin
        fin_res = q_s;
        unique case (op_q)
            3'b000:                 fin_res = prod_s[XLEN-1:0];
            3'b001, 3'b010, 3'b011: fin_res = prod_s[2*XLEN-1:XLEN];
            3'b100, 3'b101:         fin_res = q_s;
            3'b110, 3'b111:         fin_res = r_s;
            default:                fin_res = q_s;
        endcase
        if (spec_q) fin_res = spec_res_q;
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        op_d       = op_q;
        setup_d    = setup_q;
        neg_d      = neg_q;
        rneg_d     = rneg_q;
        spec_d     = spec_q;
        spec_res_d = spec_res_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        b_d        = b_q;
        res_d      = res_q;
        unique case (state_q)
            IDLE: begin
                if (!bus.i_flush && bus.i_valid) begin
                    state_d    = CALC;
                    cnt_d      = CW'(XLEN);
                    op_d       = bus.i_op;
                    setup_d    = 1'b1;
                    lo_d       = bus.i_x;
                    b_d        = bus.i_y;
                    spec_d     = bus.i_op[2] & (in_zero | in_ovf);
                    spec_res_d = '1;
                    if (in_zero) begin
                        spec_res_d = bus.i_op[1] ? bus.i_x : '1;
                    end else if (in_ovf) begin
                        spec_res_d = bus.i_op[1] ? '0
                                   : {1'b1, {(XLEN-1){1'b0}}};
                    end
                end
            end
            CALC: begin
                if (bus.i_flush) begin
                    state_d = IDLE;
                end else if (setup_q) begin
                    setup_d = 1'b0;
                    neg_d   = sx ^ sy;
                    rneg_d  = sx;
                    hi_d    = '0;
                    lo_d    = is_div ? mx : my;
                    b_d     = is_div ? my : mx;
                end else begin
                    hi_d  = hi_n;
                    lo_d  = lo_n;
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == CW'(1)) begin
                        state_d = DONE;
                        res_d   = fin_res;
                    end
                end
            end
            DONE: begin
                if (bus.i_flush || bus.i_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            op_q       <= '0;
            setup_q    <= 1'b0;
            neg_q      <= 1'b0;
            rneg_q     <= 1'b0;
            spec_q     <= 1'b0;
            spec_res_q <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            b_q        <= '0;
            res_q      <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            op_q       <= op_d;
            setup_q    <= setup_d;
            neg_q      <= neg_d;
            rneg_q     <= rneg_d;
            spec_q     <= spec_d;
            spec_res_q <= spec_res_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            b_q        <= b_d;
            res_q      <= res_d;
        end
    end

    assign bus.o_ready = (state_q == IDLE);
    assign bus.o_valid = (state_q == DONE);
    assign bus.o_res   = res_q;
endmodule

// File: tb/tb_malu_iter.sv
// Bench for malu_iter: directed vectors, handshake corner cases and
// randomized ops against an arithmetic reference model.
module tb_malu_iter;
    localparam int XLEN = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    malu_iter_if #(.XLEN(XLEN)) bus ();

    malu_iter #(.XLEN(XLEN)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus.slave)
    );

    typedef struct {
        logic [2:0]  op;
        logic [31:0] x;
        logic [31:0] y;
        logic [31:0] exp;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%h exp=%h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_model(input logic [2:0] op,
                                              input logic [31:0] x,
                                              input logic [31:0] y);
        logic [63:0] p;
        int sx, sy;
        sx = x;
        sy = y;
        case (op)
            3'd0: begin p = {32'b0, x} * {32'b0, y}; return p[31:0]; end
            3'd1: begin
                p = {{32{x[31]}}, x} * {{32{y[31]}}, y};
                return p[63:32];
            end
            3'd2: begin p = {{32{x[31]}}, x} * {32'b0, y}; return p[63:32]; end
            3'd3: begin p = {32'b0, x} * {32'b0, y}; return p[63:32]; end
            3'd4: begin
                if (y == 0) return 32'hFFFF_FFFF;
                if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return x;
                return sx / sy;
            end
            3'd5: return (y == 0) ? 32'hFFFF_FFFF : x / y;
            3'd6: begin
                if (y == 0) return x;
                if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 0;
                return sx % sy;
            end
            default: return (y == 0) ? x : x % y;
        endcase
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    task automatic start_op(input logic [2:0] op, input logic [31:0] x,
                            input logic [31:0] y);
        int n = 0;
        while (!bus.o_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!bus.o_ready) chk("ready_wait", 32'(bus.o_ready), 32'd1);
        bus.i_valid = 1'b1;
        bus.i_op    = op;
        bus.i_x     = x;
        bus.i_y     = y;
        @(posedge clk);
        #1;
        bus.i_valid = 1'b0;
        bus.i_x     = $urandom;
        bus.i_y     = $urandom;
        bus.i_op    = 3'($urandom);
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        do begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end while (!bus.o_valid && lat < 100);
    endtask

    task automatic consume();
        bus.i_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.i_ready = 1'b0;
    endtask

    task automatic watch_no_valid(input string nm);
        logic seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            seen |= bus.o_valid;
        end
        chk(nm, 32'(seen), 32'd0);
    endtask

    vec_t vecs[14];

    initial begin
        int lat;
        logic [31:0] r0;
        logic [2:0] op;
        logic [31:0] x, y;

        vecs[0]  = '{3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001};
        vecs[1]  = '{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000};
        vecs[2]  = '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
        vecs[3]  = '{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        vecs[4]  = '{3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD};
        vecs[5]  = '{3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF};
        vecs[6]  = '{3'd5, 32'd100, 32'd7, 32'd14};
        vecs[7]  = '{3'd7, 32'd100, 32'd7, 32'd2};
        vecs[8]  = '{3'd5, 32'd7, 32'd0, 32'hFFFF_FFFF};
        vecs[9]  = '{3'd7, 32'd7, 32'd0, 32'd7};
        vecs[10] = '{3'd4, 32'd5, 32'd0, 32'hFFFF_FFFF};
        vecs[11] = '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000};
        vecs[12] = '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0};
        vecs[13] = '{3'd6, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9};

        bus.i_valid = 1'b0;
        bus.i_op    = '0;
        bus.i_x     = '0;
        bus.i_y     = '0;
        bus.i_flush = 1'b0;
        bus.i_ready = 1'b0;

        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_ready", 32'(bus.o_ready), 32'd1);
        chk("rst_valid", 32'(bus.o_valid), 32'd0);
        chk("rst_res", bus.o_res, 32'd0);

        for (int i = 0; i < 14; i++) begin
            start_op(vecs[i].op, vecs[i].x, vecs[i].y);
            wait_valid(lat);
            chk($sformatf("vec%0d_lat", i), 32'(lat), 32'd33);
            chk($sformatf("vec%0d_res", i), bus.o_res, vecs[i].exp);
            consume();
        end

        // backpressure: result held while consumer stalls
        start_op(3'd5, 32'd100, 32'd7);
        wait_valid(lat);
        r0 = bus.o_res;
        chk("bp_res", r0, 32'd14);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_valid", 32'(bus.o_valid), 32'd1);
            chk("bp_ready", 32'(bus.o_ready), 32'd0);
            chk("bp_stable", bus.o_res, r0);
        end
        consume();
        @(negedge clk);
        chk("bp_idle_ready", 32'(bus.o_ready), 32'd1);
        chk("bp_idle_valid", 32'(bus.o_valid), 32'd0);

        // flush mid-calculation
        start_op(3'd4, 32'hFFFF_FFF9, 32'd2);
        repeat (4) @(posedge clk);
        #1;
        bus.i_flush = 1'b1;
        @(posedge clk);
        #1;
        bus.i_flush = 1'b0;
        chk("flush_calc_ready", 32'(bus.o_ready), 32'd1);
        watch_no_valid("flush_calc_no_valid");
        start_op(3'd7, 32'd100, 32'd7);
        wait_valid(lat);
        chk("after_flush_lat", 32'(lat), 32'd33);
        chk("after_flush_res", bus.o_res, 32'd2);
        consume();

        // flush beats a request in IDLE
        @(negedge clk);
        bus.i_valid = 1'b1;
        bus.i_flush = 1'b1;
        bus.i_op    = 3'd0;
        bus.i_x     = 32'd3;
        bus.i_y     = 32'd4;
        @(posedge clk);
        #1;
        bus.i_valid = 1'b0;
        bus.i_flush = 1'b0;
        chk("flush_idle_ready", 32'(bus.o_ready), 32'd1);
        watch_no_valid("flush_idle_no_valid");

        // flush together with ready in DONE
        start_op(3'd0, 32'd6, 32'd7);
        wait_valid(lat);
        chk("fr_res", bus.o_res, 32'd42);
        bus.i_flush = 1'b1;
        bus.i_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.i_flush = 1'b0;
        bus.i_ready = 1'b0;
        chk("fr_valid", 32'(bus.o_valid), 32'd0);
        chk("fr_ready", 32'(bus.o_ready), 32'd1);

        // reset in the middle of a calculation
        start_op(3'd1, 32'h1234_5678, 32'h9ABC_DEF0);
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("midrst_ready", 32'(bus.o_ready), 32'd1);
        chk("midrst_valid", 32'(bus.o_valid), 32'd0);
        chk("midrst_res", bus.o_res, 32'd0);
        watch_no_valid("midrst_no_valid");

        for (int i = 0; i < 1500; i++) begin
            op = 3'($urandom_range(0, 7));
            x  = pick();
            y  = pick();
            start_op(op, x, y);
            wait_valid(lat);
            chk($sformatf("rnd op=%0d x=%h y=%h", op, x, y),
                bus.o_res, ref_model(op, x, y));
            consume();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
